// File: rtl/mesi_isc_bcast_sched.sv
// mesi_isc_bcast_sched: serialises WR_BROAD/RD_BROAD requests from four CPU
// main-bus ports into one coherence transaction at a time. Each transaction
// snoops every other CPU and then enables the originating CPU.
// Optional build macro: MESI_ISC_BCAST_RR_EN selects round-robin arbitration;
// when it is undefined the arbiter is fixed priority CPU0 > CPU1 > CPU2 > CPU3.
module mesi_isc_bcast_sched #(
    parameter int unsigned MBUS_CMD_WIDTH = 3,
    parameter int unsigned CBUS_CMD_WIDTH = 3,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd0_i,
    input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd1_i,
    input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd2_i,
    input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd3_i,
    input  logic [ADDR_WIDTH-1:0]     mbus_addr0_i,
    input  logic [ADDR_WIDTH-1:0]     mbus_addr1_i,
    input  logic [ADDR_WIDTH-1:0]     mbus_addr2_i,
    input  logic [ADDR_WIDTH-1:0]     mbus_addr3_i,
    output logic                      mbus_ack0_o,
    output logic                      mbus_ack1_o,
    output logic                      mbus_ack2_o,
    output logic                      mbus_ack3_o,
    output logic [ADDR_WIDTH-1:0]     cbus_addr_o,
    output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd0_o,
    output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd1_o,
    output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd2_o,
    output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd3_o,
    input  logic                      cbus_ack0_i,
    input  logic                      cbus_ack1_i,
    input  logic                      cbus_ack2_i,
    input  logic                      cbus_ack3_i,
    output logic                      bcast_busy_o
);

    localparam int unsigned NCPU = 4;
    localparam int unsigned IDXW = 2;

    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR_BROAD = MBUS_CMD_WIDTH'(3);
    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD_BROAD = MBUS_CMD_WIDTH'(4);

    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_NOP      = CBUS_CMD_WIDTH'(0);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_RD    = CBUS_CMD_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SNOOP  = 2'd1,
        ST_ENABLE = 2'd2
    } state_t;

    // Per-CPU views of the individual ports
    logic [NCPU-1:0][MBUS_CMD_WIDTH-1:0] mcmd;
    logic [NCPU-1:0][ADDR_WIDTH-1:0]     maddr;
    logic [NCPU-1:0]                     cack;
    logic [NCPU-1:0]                     req;

    assign mcmd  = {mbus_cmd3_i, mbus_cmd2_i, mbus_cmd1_i, mbus_cmd0_i};
    assign maddr = {mbus_addr3_i, mbus_addr2_i, mbus_addr1_i, mbus_addr0_i};
    assign cack  = {cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i};

    // Transaction state
    state_t                              state_q, state_d;
    logic [IDXW-1:0]                     src_q, src_d;
    logic                                wr_q, wr_d;
    logic [NCPU-1:0]                     pend_q, pend_d;
    logic [ADDR_WIDTH-1:0]               addr_q, addr_d;
    logic [NCPU-1:0]                     mack_q, mack_d;
    logic [NCPU-1:0][CBUS_CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic                                busy_q, busy_d;

    // Arbiter result
    logic                                grant_valid;
    logic [IDXW-1:0]                     grant_idx;

    // Only the two broadcast commands count as requests
    always_comb begin
        for (int k = 0; k < NCPU; k++) begin
            req[k] = (mcmd[k] == MBUS_WR_BROAD) || (mcmd[k] == MBUS_RD_BROAD);
        end
    end

`ifdef MESI_ISC_BCAST_RR_EN
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] cand;

    // Round-robin pick: first requester at or after the pointer, wrapping 3->0
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = NCPU - 1; i >= 0; i--) begin
            cand = ptr_q + IDXW'(i);
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end
`else
    // Fixed-priority pick: lowest CPU index wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NCPU - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = IDXW'(i);
            end
        end
    end
`endif

    // Next-state, next-transaction and next-output logic
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        wr_d    = wr_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        mack_d  = '0;
`ifdef MESI_ISC_BCAST_RR_EN
        ptr_d   = ptr_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d           = ST_SNOOP;
                    src_d             = grant_idx;
                    wr_d              = (mcmd[grant_idx] == MBUS_WR_BROAD);
                    addr_d            = maddr[grant_idx];
                    pend_d            = ~(NCPU'(1) << grant_idx);
                    mack_d[grant_idx] = 1'b1;
`ifdef MESI_ISC_BCAST_RR_EN
                    ptr_d             = grant_idx + IDXW'(1);
`endif
                end
            end
            ST_SNOOP: begin
                // Acks on lanes no longer pending (including src) fall out here
                pend_d = pend_q & ~cack;
                if (pend_d == '0) begin
                    state_d = ST_ENABLE;
                end
            end
            ST_ENABLE: begin
                if (cack[src_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = '0;
            end
        endcase

        for (int k = 0; k < NCPU; k++) begin
            cmd_d[k] = CBUS_NOP;
            if ((state_d == ST_SNOOP) && pend_d[k]) begin
                cmd_d[k] = wr_d ? CBUS_WR_SNOOP : CBUS_RD_SNOOP;
            end else if ((state_d == ST_ENABLE) && (src_d == IDXW'(k))) begin
                cmd_d[k] = wr_d ? CBUS_EN_WR : CBUS_EN_RD;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset silently aborts any transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            wr_q    <= 1'b0;
            pend_q  <= '0;
            addr_q  <= '0;
            mack_q  <= '0;
            cmd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            wr_q    <= wr_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            mack_q  <= mack_d;
            cmd_q   <= cmd_d;
            busy_q  <= busy_d;
        end
    end

`ifdef MESI_ISC_BCAST_RR_EN
    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign mbus_ack0_o  = mack_q[0];
    assign mbus_ack1_o  = mack_q[1];
    assign mbus_ack2_o  = mack_q[2];
    assign mbus_ack3_o  = mack_q[3];
    assign cbus_cmd0_o  = cmd_q[0];
    assign cbus_cmd1_o  = cmd_q[1];
    assign cbus_cmd2_o  = cmd_q[2];
    assign cbus_cmd3_o  = cmd_q[3];
    assign cbus_addr_o  = addr_q;
    assign bcast_busy_o = busy_q;

endmodule

// File: tb/tb_mesi_isc_bcast_sched.sv
// Bench for mesi_isc_bcast_sched: directed vector table (with expected values
// written out by hand) followed by randomized traffic checked against a
// transaction-level reference model.
module tb_mesi_isc_bcast_sched;

    localparam logic [31:0] A0 = 32'h0000_00A0;
    localparam logic [31:0] A1 = 32'h0000_1000;
    localparam logic [31:0] A2 = 32'h0000_2000;
    localparam logic [31:0] A3 = 32'h0000_00B0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  mcmd  [4];
    logic [31:0] maddr [4];
    logic [3:0]  cack = 4'h0;

    wire         mack0, mack1, mack2, mack3;
    wire [2:0]   ccmd0, ccmd1, ccmd2, ccmd3;
    wire [31:0]  caddr;
    wire         busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mesi_isc_bcast_sched dut (
        .clk          (clk),
        .rst          (rst),
        .mbus_cmd0_i  (mcmd[0]),
        .mbus_cmd1_i  (mcmd[1]),
        .mbus_cmd2_i  (mcmd[2]),
        .mbus_cmd3_i  (mcmd[3]),
        .mbus_addr0_i (maddr[0]),
        .mbus_addr1_i (maddr[1]),
        .mbus_addr2_i (maddr[2]),
        .mbus_addr3_i (maddr[3]),
        .mbus_ack0_o  (mack0),
        .mbus_ack1_o  (mack1),
        .mbus_ack2_o  (mack2),
        .mbus_ack3_o  (mack3),
        .cbus_addr_o  (caddr),
        .cbus_cmd0_o  (ccmd0),
        .cbus_cmd1_o  (ccmd1),
        .cbus_cmd2_o  (ccmd2),
        .cbus_cmd3_o  (ccmd3),
        .cbus_ack0_i  (cack[0]),
        .cbus_ack1_i  (cack[1]),
        .cbus_ack2_i  (cack[2]),
        .cbus_ack3_i  (cack[3]),
        .bcast_busy_o (busy)
    );

    // One directed cycle: inputs applied, outputs expected after the next edge.
    // Command fields are written in octal, digit order lane3 lane2 lane1 lane0.
    typedef struct {
        logic            rst;
        logic [3:0][2:0] cmd;
        logic [3:0]      ack;
        logic [3:0][2:0] exp_cmd;
        logic [3:0]      exp_mack;
        logic            exp_busy;
        logic [31:0]     exp_addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [11:0] c, input logic [3:0] a,
                                input logic [11:0] ec, input logic [3:0] em,
                                input logic eb, input logic [31:0] ea);
        vec_t v;
        v.rst = r; v.cmd = c; v.ack = a;
        v.exp_cmd = ec; v.exp_mack = em; v.exp_busy = eb; v.exp_addr = ea;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [11:0] dut_cmds();
        return {ccmd3, ccmd2, ccmd1, ccmd0};
    endfunction

    function automatic logic [3:0] dut_macks();
        return {mack3, mack2, mack1, mack0};
    endfunction

    // Reference model: transaction phase plus the set of CPUs still to answer a snoop
    int          m_phase;   // 0 idle, 1 snooping, 2 enabling originator
    int          m_src;
    bit          m_wr;
    bit          m_pend [4];
    bit          m_mack [4];
    logic [31:0] m_addr;
    int          m_ptr;

    task automatic model_step();
        int  w;
        int  k;
        bit  any;
        for (int i = 0; i < 4; i++) m_mack[i] = 1'b0;
        if (rst) begin
            m_phase = 0; m_src = 0; m_wr = 1'b0; m_addr = '0; m_ptr = 0;
            for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
        end else if (m_phase == 0) begin
            w = -1;
            for (int i = 0; i < 4; i++) begin
`ifdef MESI_ISC_BCAST_RR_EN
                k = (m_ptr + i) % 4;
`else
                k = i;
`endif
                if (w < 0 && (mcmd[k] == 3'd3 || mcmd[k] == 3'd4)) w = k;
            end
            if (w >= 0) begin
                m_phase = 1; m_src = w; m_wr = (mcmd[w] == 3'd3); m_addr = maddr[w];
                for (int i = 0; i < 4; i++) m_pend[i] = (i != w);
                m_mack[w] = 1'b1;
                m_ptr = (w + 1) % 4;
            end
        end else if (m_phase == 1) begin
            any = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (cack[i]) m_pend[i] = 1'b0;
                any |= m_pend[i];
            end
            if (!any) m_phase = 2;
        end else begin
            if (cack[m_src]) m_phase = 0;
        end
    endtask

    function automatic logic [11:0] model_cmds();
        logic [3:0][2:0] c;
        for (int i = 0; i < 4; i++) begin
            c[i] = 3'd0;
            if (m_phase == 1 && m_pend[i]) c[i] = m_wr ? 3'd1 : 3'd2;
            else if (m_phase == 2 && i == m_src) c[i] = m_wr ? 3'd3 : 3'd4;
        end
        return c;
    endfunction

    function automatic logic [3:0] model_macks();
        return {m_mack[3], m_mack[2], m_mack[1], m_mack[0]};
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) mcmd[i] = 3'd0;
        maddr[0] = A0; maddr[1] = A1; maddr[2] = A2; maddr[3] = A3;

        // Reset held two cycles with requests and acks present
        tbl.push_back(mk(1, 12'o3333, 4'hF, 12'o0000, 4'b0000, 0, 32'h0));
        tbl.push_back(mk(1, 12'o4444, 4'hF, 12'o0000, 4'b0000, 0, 32'h0));
        // CPU1 WR_BROAD; stray acks on src and already-acked lanes are ignored
        tbl.push_back(mk(0, 12'o0030, 4'b0000, 12'o1101, 4'b0010, 1, A1));
        tbl.push_back(mk(0, 12'o0000, 4'b0010, 12'o1101, 4'b0000, 1, A1));
        tbl.push_back(mk(0, 12'o0000, 4'b0100, 12'o1001, 4'b0000, 1, A1));
        tbl.push_back(mk(0, 12'o0000, 4'b0110, 12'o1001, 4'b0000, 1, A1));
        tbl.push_back(mk(0, 12'o0000, 4'b1001, 12'o0030, 4'b0000, 1, A1));
        tbl.push_back(mk(0, 12'o0000, 4'b0000, 12'o0030, 4'b0000, 1, A1));
        tbl.push_back(mk(0, 12'o0000, 4'b0010, 12'o0000, 4'b0000, 0, A1));
        // Non-broadcast commands are ignored; address holds
        tbl.push_back(mk(0, 12'o7521, 4'b0000, 12'o0000, 4'b0000, 0, A1));
        // Simultaneous CPU0 RD_BROAD and CPU3 WR_BROAD straight after reset
        tbl.push_back(mk(1, 12'o0000, 4'b0000, 12'o0000, 4'b0000, 0, 32'h0));
        tbl.push_back(mk(0, 12'o3004, 4'b0000, 12'o2220, 4'b0001, 1, A0));
        tbl.push_back(mk(0, 12'o3000, 4'b1110, 12'o0004, 4'b0000, 1, A0));
        tbl.push_back(mk(0, 12'o3000, 4'b0001, 12'o0000, 4'b0000, 0, A0));
        tbl.push_back(mk(0, 12'o3000, 4'b0000, 12'o0111, 4'b1000, 1, A3));
        tbl.push_back(mk(0, 12'o0000, 4'b0111, 12'o3000, 4'b0000, 1, A3));
        tbl.push_back(mk(0, 12'o0000, 4'b1000, 12'o0000, 4'b0000, 0, A3));
        // Reset during SNOOP with one lane outstanding, requester re-granted
        tbl.push_back(mk(0, 12'o0400, 4'b0000, 12'o2022, 4'b0100, 1, A2));
        tbl.push_back(mk(0, 12'o0400, 4'b0011, 12'o2000, 4'b0000, 1, A2));
        tbl.push_back(mk(1, 12'o0400, 4'b0000, 12'o0000, 4'b0000, 0, 32'h0));
        tbl.push_back(mk(0, 12'o0400, 4'b0000, 12'o2022, 4'b0100, 1, A2));
        tbl.push_back(mk(0, 12'o0000, 4'b1011, 12'o0400, 4'b0000, 1, A2));
        tbl.push_back(mk(0, 12'o0000, 4'b0100, 12'o0000, 4'b0000, 0, A2));

        // Hand sequence: grant CPU3, then CPU0 and CPU3 together -> CPU0 first
        tbl.push_back(mk(1, 12'o0000, 4'b0000, 12'o0000, 4'b0000, 0, 32'h0));
        tbl.push_back(mk(0, 12'o3000, 4'b0000, 12'o0111, 4'b1000, 1, A3));
        tbl.push_back(mk(0, 12'o0000, 4'b0111, 12'o3000, 4'b0000, 1, A3));
        tbl.push_back(mk(0, 12'o0000, 4'b1000, 12'o0000, 4'b0000, 0, A3));
        tbl.push_back(mk(0, 12'o3003, 4'b0000, 12'o1110, 4'b0001, 1, A0));
        tbl.push_back(mk(0, 12'o3000, 4'b1110, 12'o0003, 4'b0000, 1, A0));
        tbl.push_back(mk(0, 12'o3000, 4'b0001, 12'o0000, 4'b0000, 0, A0));
        tbl.push_back(mk(0, 12'o3000, 4'b0000, 12'o0111, 4'b1000, 1, A3));
        tbl.push_back(mk(0, 12'o0000, 4'b0111, 12'o3000, 4'b0000, 1, A3));
        tbl.push_back(mk(0, 12'o0000, 4'b1000, 12'o0000, 4'b0000, 0, A3));
        // Hand sequence: grant CPU1, then CPU0 and CPU2 together (arbiter-dependent)
        tbl.push_back(mk(0, 12'o0030, 4'b0000, 12'o1101, 4'b0010, 1, A1));
        tbl.push_back(mk(0, 12'o0000, 4'b1101, 12'o0030, 4'b0000, 1, A1));
        tbl.push_back(mk(0, 12'o0000, 4'b0010, 12'o0000, 4'b0000, 0, A1));
`ifdef MESI_ISC_BCAST_RR_EN
        tbl.push_back(mk(0, 12'o0303, 4'b0000, 12'o1011, 4'b0100, 1, A2));
        tbl.push_back(mk(0, 12'o0003, 4'b1011, 12'o0300, 4'b0000, 1, A2));
        tbl.push_back(mk(0, 12'o0003, 4'b0100, 12'o0000, 4'b0000, 0, A2));
        tbl.push_back(mk(0, 12'o0003, 4'b0000, 12'o1110, 4'b0001, 1, A0));
        tbl.push_back(mk(0, 12'o0000, 4'b1110, 12'o0003, 4'b0000, 1, A0));
        tbl.push_back(mk(0, 12'o0000, 4'b0001, 12'o0000, 4'b0000, 0, A0));
`else
        tbl.push_back(mk(0, 12'o0303, 4'b0000, 12'o1110, 4'b0001, 1, A0));
        tbl.push_back(mk(0, 12'o0300, 4'b1110, 12'o0003, 4'b0000, 1, A0));
        tbl.push_back(mk(0, 12'o0300, 4'b0001, 12'o0000, 4'b0000, 0, A0));
        tbl.push_back(mk(0, 12'o0300, 4'b0000, 12'o1011, 4'b0100, 1, A2));
        tbl.push_back(mk(0, 12'o0000, 4'b1011, 12'o0300, 4'b0000, 1, A2));
        tbl.push_back(mk(0, 12'o0000, 4'b0100, 12'o0000, 4'b0000, 0, A2));
`endif

        // Directed phase
        for (int v = 0; v < tbl.size(); v++) begin
            rst  = tbl[v].rst;
            cack = tbl[v].ack;
            for (int i = 0; i < 4; i++) mcmd[i] = tbl[v].cmd[i];
            @(posedge clk);
            #1;
            check("vec_cbus_cmd", v, 32'(dut_cmds()),  32'(tbl[v].exp_cmd));
            check("vec_mbus_ack", v, 32'(dut_macks()), 32'(tbl[v].exp_mack));
            check("vec_busy",     v, 32'(busy),        32'(tbl[v].exp_busy));
            check("vec_addr",     v, caddr,            tbl[v].exp_addr);
        end

        // Random phase, starting from a known reset
        rst = 1'b1;
        cack = 4'h0;
        for (int i = 0; i < 4; i++) mcmd[i] = 3'd0;
        @(posedge clk);
        model_step();
        #1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 99) < 30) mcmd[i] = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd4;
                else mcmd[i] = 3'($urandom_range(0, 7));
                maddr[i] = $urandom;
                cack[i]  = ($urandom_range(0, 99) < 40);
            end
            @(posedge clk);
            model_step();
            #1;
            check("rnd_cbus_cmd", c, 32'(dut_cmds()),  32'(model_cmds()));
            check("rnd_mbus_ack", c, 32'(dut_macks()), 32'(model_macks()));
            check("rnd_busy",     c, 32'(busy),        32'(m_phase != 0));
            check("rnd_addr",     c, caddr,            m_addr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
